// File: rtl/riscv_mem_pkg.sv
// Shared encodings and byte-lane helpers for the unified RV32 memory.
package riscv_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {D_IDLE, D_WAIT} d_state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 4'b0001;
      SZ_H:    return 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return (sz == SZ_H && a[0]) || (sz == SZ_W && a != 2'b00) || (sz == 2'b11);
  endfunction

  function automatic logic [31:0] ld_extend(input logic [31:0] raw, input logic [1:0] sz,
                                            input logic uns);
    case (sz)
      SZ_B:    return uns ? {24'b0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      SZ_H:    return uns ? {16'b0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_lat_pipe.sv
// Fixed-latency valid/data shift pipe; flush drops everything in flight.
module mem_lat_pipe #(
  parameter int LAT = 1,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         any_vld
);

  logic [LAT:1]        vld_pipe;
  logic [LAT:1][W-1:0] dat_pipe;

  always_ff @(posedge clk) begin
    if (flush) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_vld;
      dat_pipe[1] <= in_data;
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_vld  = vld_pipe[LAT];
  assign out_data = dat_pipe[LAT];
  assign any_vld  = |vld_pipe;

endmodule

// File: rtl/riscv_unified_mem.sv
// Unified byte array serving fetch, the register file window and data accesses,
// with fixed read latencies and error pulses for illegal data requests.
module riscv_unified_mem
  import riscv_mem_pkg::*;
#(
  parameter int MEM_BYTES = 512,
  parameter int ADDR_W    = 32,
  parameter int REG_BASE  = 0,
  parameter int IF_LAT    = 1,
  parameter int D_LAT     = 2,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [31:0]       rs1_data,
  output logic [31:0]       rs2_data,
  input  logic              rd_we,
  input  logic [4:0]        rd_addr,
  input  logic [31:0]       rd_wdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_uns,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err
);

  localparam int AW = $clog2(MEM_BYTES);

  reg [7:0] mem [0:MEM_BYTES-1];

  function automatic logic [31:0] rd_word(input logic [AW-1:0] a);
    return {mem[a + AW'(3)], mem[a + AW'(2)], mem[a + AW'(1)], mem[a]};
  endfunction

  function automatic logic [AW-1:0] reg_idx(input logic [4:0] r);
    return AW'(REG_BASE) + AW'({r, 2'b00});
  endfunction

  // ---------------- fetch ----------------
  logic          if_acc, if_any, if_busy;
  logic [AW-1:0] if_idx;
  logic [31:0]   if_word;

  assign if_idx   = {if_addr[AW-1:2], 2'b00};
  // The request being delivered this cycle no longer counts as outstanding.
  assign if_busy  = if_any & ~if_valid;
  assign if_ready = ~reset & ~if_busy;
  assign if_acc   = if_req & if_ready;
  assign if_word  = if_acc ? rd_word(if_idx) : '0;

  mem_lat_pipe #(.LAT(IF_LAT), .W(32)) u_if_pipe (
    .clk     (clk),
    .flush   (reset),
    .in_vld  (if_acc),
    .in_data (if_word),
    .out_vld (if_valid),
    .out_data(if_rdata),
    .any_vld (if_any)
  );

  // ---------------- register ports ----------------
  logic          rd_hit;
  logic [AW-1:0] rd_idx;

  assign rd_hit = ~reset & rd_we & (rd_addr != 5'd0);
  assign rd_idx = reg_idx(rd_addr);

  function automatic logic [31:0] rs_read(input logic [4:0] r);
    if (r == 5'd0)                return '0;
    if (rd_hit && rd_addr == r)   return rd_wdata;
    return rd_word(reg_idx(r));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_data <= '0;
      rs2_data <= '0;
    end else begin
      rs1_data <= rs_read(rs1_addr);
      rs2_data <= rs_read(rs2_addr);
    end
  end

  // ---------------- data port ----------------
  d_state_e      state, state_n;
  logic [1:0]    cnt, cnt_n;
  logic          d_acc, d_bad, ld_acc, st_acc, ld_any;
  logic [AW-1:0] d_idx;
  logic [3:0]    st_mask;
  logic [31:0]   ld_word;

  assign d_idx   = d_addr[AW-1:0];
  assign d_ready = ~reset & (state == D_IDLE);
  assign d_acc   = d_req & d_ready;
  assign d_bad   = misaligned(d_size, d_addr[1:0]) | $isunknown({d_we, d_size, d_uns, d_addr});
  assign ld_acc  = d_acc & ~d_we & ~d_bad;
  assign st_acc  = d_acc &  d_we & ~d_bad;
  assign st_mask = st_acc ? lane_mask(d_size) : 4'b0000;
  assign ld_word = ld_acc ? ld_extend(rd_word(d_idx), d_size, d_uns) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= D_IDLE;
      cnt   <= '0;
      d_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      d_err <= d_acc & d_bad;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      D_IDLE: if (ld_acc) begin
        state_n = D_WAIT;
        cnt_n   = 2'(D_LAT - 1);
      end
      D_WAIT: begin
        if (cnt == 2'd0) state_n = D_IDLE;
        else             cnt_n   = cnt - 2'd1;
      end
      default: state_n = D_IDLE;
    endcase
  end

  mem_lat_pipe #(.LAT(D_LAT), .W(32)) u_ld_pipe (
    .clk     (clk),
    .flush   (reset),
    .in_vld  (ld_acc),
    .in_data (ld_word),
    .out_vld (d_rvalid),
    .out_data(d_rdata),
    .any_vld (ld_any)
  );

  // Register write is applied last so it overrides overlapping store bytes.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (st_mask[k]) mem[d_idx + AW'(k)] <= d_wdata[8*k +: 8];
    if (rd_hit)
      for (int k = 0; k < 4; k++) mem[rd_idx + AW'(k)] <= rd_wdata[8*k +: 8];
  end

  logic unused_bits;
  assign unused_bits = ^{if_addr[ADDR_W-1:AW], if_addr[1:0], d_addr[ADDR_W-1:AW], ld_any};

endmodule

// File: tb/tb_riscv_unified_mem.sv
// Directed bench for riscv_unified_mem: reset, fetch, registers, loads, errors, collisions.
module tb_riscv_unified_mem;
  import riscv_mem_pkg::*;

  localparam int MEM_BYTES = 512;
  localparam int REG_BASE  = 0;
  localparam int IF_LAT    = 1;
  localparam int D_LAT     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_ready, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, rd_wdata;
  logic        rd_we;
  logic        d_req, d_we, d_uns, d_ready, d_rvalid, d_err;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;

  int n_chk = 0;
  int n_err = 0;

  riscv_unified_mem #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32), .REG_BASE(REG_BASE),
                      .IF_LAT(IF_LAT), .D_LAT(D_LAT), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid), .if_rdata(if_rdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_uns(d_uns), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One-cycle data request; caller guarantees d_ready.
  task automatic d_drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    d_req = 1'b1; d_we = we; d_size = sz; d_uns = uns; d_addr = addr; d_wdata = wdata;
    step();
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp);
    int lat;
    d_drive(1'b0, sz, uns, addr, 32'h0);
    lat = 1;
    while (!d_rvalid && lat < 12) begin
      step();
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(D_LAT));
    chk(tag, d_rdata, exp);
    step();
  endtask

  task automatic chk_err(input string tag, input logic we, input logic [1:0] sz,
                         input logic [31:0] addr);
    int nv;
    d_drive(we, sz, 1'b0, addr, 32'h1234_5678);
    chk({tag, "_err"}, 32'(d_err), 32'd1);
    chk({tag, "_rdy"}, 32'(d_ready), 32'd1);
    nv = d_rvalid ? 1 : 0;
    step();
    chk({tag, "_errfall"}, 32'(d_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (d_rvalid) nv++;
      step();
    end
    chk({tag, "_norvalid"}, 32'(nv), 32'd0);
  endtask

  initial begin
    int lat, nv;
    reset = 1'b1; if_req = 1'b0; if_addr = '0; rs1_addr = '0; rs2_addr = '0;
    rd_we = 1'b0; rd_addr = '0; rd_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = SZ_W; d_uns = 1'b0; d_addr = '0; d_wdata = '0;
    step(); step();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_d_err",    32'(d_err),    32'd0);
    chk("rst_rs1",      rs1_data,      32'd0);
    chk("rst_d_ready",  32'(d_ready),  32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_d_ready",  32'(d_ready),  32'd1);
    chk("post_rst_if_ready", 32'(if_ready), 32'd1);
    step();

    // 1: reset one cycle after a load is accepted drops the load
    d_drive(1'b0, SZ_W, 1'b0, 32'h100, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("midrst_ready", 32'(d_ready), 32'd1);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      if (d_rvalid) nv++;
      step();
    end
    chk("midrst_norvalid", 32'(nv), 32'd0);

    // 2: fetch
    d_drive(1'b1, SZ_W, 1'b0, 32'h40, 32'h0010_0513);
    if_req = 1'b1; if_addr = 32'h40;
    step();
    if_req = 1'b0;
    lat = 1;
    while (!if_valid && lat < 12) begin
      step();
      lat++;
    end
    chk("if_lat",   32'(lat), 32'(IF_LAT));
    chk("if_rdata", if_rdata, 32'h0010_0513);
    step();
    chk("if_pulse", 32'(if_valid), 32'd0);
    if_req = 1'b1; if_addr = 32'h43;
    step();
    if_req = 1'b0;
    chk("if_unaligned", if_rdata, 32'h0010_0513);

    // 3: register bypass, array read-back, x0
    rd_we = 1'b1; rd_addr = 5'd5; rd_wdata = 32'hDEAD_BEEF; rs1_addr = 5'd5;
    step();
    rd_we = 1'b0;
    chk("rs1_bypass", rs1_data, 32'hDEAD_BEEF);
    rs2_addr = 5'd5;
    step();
    chk("rs2_array", rs2_data, 32'hDEAD_BEEF);
    rd_we = 1'b1; rd_addr = 5'd0; rd_wdata = 32'h1; rs1_addr = 5'd0;
    step();
    rd_we = 1'b0;
    chk("x0_bypass", rs1_data, 32'd0);
    step();
    chk("x0_read", rs1_data, 32'd0);
    do_load("lw_x5", SZ_W, 1'b0, REG_BASE + 20, 32'hDEAD_BEEF);

    // 4: loads with extension
    d_drive(1'b1, SZ_W, 1'b0, 32'h100, 32'h8000_FF80);
    do_load("lb",  SZ_B, 1'b0, 32'h100, 32'hFFFF_FF80);
    do_load("lbu", SZ_B, 1'b1, 32'h100, 32'h0000_0080);
    do_load("lh",  SZ_H, 1'b0, 32'h102, 32'hFFFF_8000);
    do_load("lhu", SZ_H, 1'b1, 32'h102, 32'h0000_8000);
    do_load("lw",  SZ_W, 1'b0, 32'h100, 32'h8000_FF80);

    // 5: errors and wrap
    chk_err("lw_mis", 1'b0, SZ_W, 32'h101);
    chk_err("sw_mis", 1'b1, SZ_W, 32'h101);
    chk_err("sh_mis", 1'b1, SZ_H, 32'h103);
    chk_err("sz11",   1'b0, 2'b11, 32'h100);
    do_load("lw_unchanged", SZ_W, 1'b0, 32'h100, 32'h8000_FF80);
    d_drive(1'b1, SZ_W, 1'b0, MEM_BYTES, 32'hCAFE_F00D);
    do_load("wrap_lw0", SZ_W, 1'b0, 32'h0, 32'hCAFE_F00D);

    // 6: same-edge store and register write
    rd_we = 1'b1; rd_addr = 5'd3; rd_wdata = 32'h1111_1111;
    d_drive(1'b1, SZ_W, 1'b0, REG_BASE + 12, 32'hAAAA_AAAA);
    rd_we = 1'b0;
    do_load("coll_full", SZ_W, 1'b0, REG_BASE + 12, 32'h1111_1111);
    rs1_addr = 5'd3;
    step();
    chk("coll_rs1", rs1_data, 32'h1111_1111);
    rd_we = 1'b1; rd_addr = 5'd3; rd_wdata = 32'h2222_2222;
    d_drive(1'b1, SZ_H, 1'b0, REG_BASE + 16, 32'h0000_CCCC);
    rd_we = 1'b0;
    do_load("coll_x3",   SZ_W, 1'b0, REG_BASE + 12, 32'h2222_2222);
    do_load("coll_x4lo", SZ_H, 1'b1, REG_BASE + 16, 32'h0000_CCCC);

    // back-to-back stores at one per cycle
    d_req = 1'b1; d_we = 1'b1; d_size = SZ_B; d_addr = 32'h180; d_wdata = 32'h11;
    step();
    d_addr = 32'h181; d_wdata = 32'h22;
    step();
    d_req = 1'b0; d_we = 1'b0;
    do_load("b2b_st", SZ_H, 1'b1, 32'h180, 32'h0000_2211);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
